// File: rtl/instr_fetch_seq_if.sv
// Purpose : bus bundle for the MSP430 fetch/decode sequencer.
//   Carries the request/ack memory port, the flush/redirect request and the
//   valid/ready decoded-instruction port toward execute.
// Modports: master = sequencer (drives mem_req/mem_addr and dec_*),
//           slave  = environment (memory, branch unit, execute).
interface instr_fetch_seq_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              dec_valid;
  logic              dec_ready;
  logic [15:0]       dec_instr;
  logic [15:0]       dec_ext0;
  logic [15:0]       dec_ext1;
  logic [1:0]        dec_len;
  logic [1:0]        dec_fmt;
  logic [ADDR_W-1:0] dec_pc;
  logic [2:0]        q_level;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    input  flush, flush_pc,
    output dec_valid, dec_instr, dec_ext0, dec_ext1, dec_len, dec_fmt, dec_pc,
    output q_level,
    input  dec_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    output flush, flush_pc,
    input  dec_valid, dec_instr, dec_ext0, dec_ext1, dec_len, dec_fmt, dec_pc,
    input  q_level,
    output dec_ready
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// Purpose : MSP430 fetch/decode sequencer. Fetches an opcode plus its 0-2
//   extension words, classifies it (Format I / II / Jump / illegal) and queues
//   complete bundles toward execute, so operand words never reach execute as
//   opcodes. Flush redirects fetch and discards all queued/in-flight work.
// Ports   : clk, rst_n (async active-low)
//           bus (instr_fetch_seq_if.master): mem_req/mem_addr/mem_ack/mem_rdata,
//           flush/flush_pc, dec_valid/dec_ready, dec_instr/ext0/ext1/len/fmt/pc,
//           q_level.
module instr_fetch_seq #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'hC000)
) (
  input logic clk,
  input logic rst_n,
  instr_fetch_seq_if.master bus
);

  localparam int unsigned IDX_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [1:0] FMT_ILL = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_II  = 2'd2;
  localparam logic [1:0] FMT_J   = 2'd3;

  typedef enum logic [1:0] {S_OP, S_EXT0, S_EXT1} state_e;

  typedef struct packed {
    logic [15:0]       instr;
    logic [15:0]       ext0;
    logic [15:0]       ext1;
    logic [1:0]        len;
    logic [1:0]        fmt;
    logic [ADDR_W-1:0] pc;
  } bundle_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  bundle_t           asm_q, asm_d;
  logic              asm_full_q, asm_full_d;
  bundle_t           q_q [QDEPTH];
  bundle_t           q_d [QDEPTH];
  logic [2:0]        level_q, level_d;
  logic              dec_valid_q, dec_valid_d;

  logic [DATA_W-1:0] w;
  logic [3:0]        sa;
  logic [1:0]        as_m;
  logic [1:0]        d_fmt;
  logic              src_ext, dst_ext;
  logic [1:0]        n_ext;
  logic              ack_fire, pop, push;

  // Opcode classification and extension-word count of the returned word
  always_comb begin
    w       = bus.mem_rdata;
    as_m    = w[5:4];
    sa      = w[11:8];
    d_fmt   = FMT_ILL;
    dst_ext = 1'b0;
    if (w[15:13] == 3'b001) begin
      d_fmt = FMT_J;
    end else if (w[15:12] >= 4'h4) begin
      d_fmt   = FMT_I;
      dst_ext = w[7];
    end else if (w[15:10] == 6'b000100 && w[9:7] != 3'b111) begin
      d_fmt = FMT_II;
      sa    = w[3:0];
    end
    // Constant generators (SA=3, SA=2 with As=1x) never take a source word
    src_ext = (d_fmt == FMT_I || d_fmt == FMT_II) &&
              ((as_m == 2'b01 && sa != 4'd3) || (as_m == 2'b11 && sa == 4'd0));
    n_ext   = 2'(src_ext) + 2'(dst_ext);
  end

  // Next-state: queue, assembly register, fetch FSM and request
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    asm_d      = asm_q;
    asm_full_d = asm_full_q;
    q_d        = q_q;
    level_d    = level_q;

    ack_fire = req_q & bus.mem_ack;
    pop      = dec_valid_q & bus.dec_ready;
    push     = asm_full_q & ((level_q < 3'(QDEPTH)) | pop);

    // Shift-register FIFO: slot 0 is always the head
    if (pop) begin
      for (int i = 0; i < int'(QDEPTH) - 1; i++) q_d[IDX_W'(i)] = q_q[IDX_W'(i + 1)];
      q_d[IDX_W'(QDEPTH - 1)] = '0;
      level_d = level_d - 3'd1;
    end
    if (push) begin
      q_d[IDX_W'(level_d)] = asm_q;
      level_d    = level_d + 3'd1;
      asm_full_d = 1'b0;
    end

    if (ack_fire) begin
      pc_d = pc_q + ADDR_W'(2);
      case (state_q)
        S_OP: begin
          asm_d.instr = w[15:0];
          asm_d.ext0  = '0;
          asm_d.ext1  = '0;
          asm_d.len   = n_ext + 2'd1;
          asm_d.fmt   = d_fmt;
          asm_d.pc    = pc_q;
          if (n_ext == 2'd0) asm_full_d = 1'b1;
          else               state_d    = S_EXT0;
        end
        S_EXT0: begin
          asm_d.ext0 = w[15:0];
          if (asm_q.len == 2'd2) begin
            asm_full_d = 1'b1;
            state_d    = S_OP;
          end else begin
            state_d = S_EXT1;
          end
        end
        S_EXT1: begin
          asm_d.ext1 = w[15:0];
          asm_full_d = 1'b1;
          state_d    = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end

    // A request is held until acked. A new opcode fetch only starts when the
    // queue plus the assembly register have room, so the final word of any
    // started instruction always finds the assembly register free.
    if (req_q && !bus.mem_ack) req_d = 1'b1;
    else if (state_d != S_OP)  req_d = 1'b1;
    else req_d = (4'(level_d) + 4'(asm_full_d)) < 4'(QDEPTH);

    if (bus.flush) begin
      state_d    = S_OP;
      pc_d       = bus.flush_pc & ~ADDR_W'(1);
      req_d      = 1'b0;
      asm_d      = '0;
      asm_full_d = 1'b0;
      q_d        = '{default: '0};
      level_d    = '0;
    end

    dec_valid_d = (level_d != 3'd0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_OP;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      q_q         <= '{default: '0};
      level_q     <= '0;
      dec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      asm_q       <= asm_d;
      asm_full_q  <= asm_full_d;
      q_q         <= q_d;
      level_q     <= level_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = pc_q;
  assign bus.dec_valid = dec_valid_q;
  assign bus.dec_instr = q_q[0].instr;
  assign bus.dec_ext0  = q_q[0].ext0;
  assign bus.dec_ext1  = q_q[0].ext1;
  assign bus.dec_len   = q_q[0].len;
  assign bus.dec_fmt   = q_q[0].fmt;
  assign bus.dec_pc    = q_q[0].pc;
  assign bus.q_level   = level_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Purpose : scoreboard bench for instr_fetch_seq. Directed programs are placed
//   in a sparse memory model; expected bundles are queued when a program is
//   issued and a monitor pops and compares each bundle execute accepts.
module tb_instr_fetch_seq;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] ext0;
    logic [15:0] ext1;
    logic [1:0]  len;
    logic [1:0]  fmt;
    logic [15:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        flush = 1'b0;
  logic [15:0] flush_pc = '0;
  logic        dec_ready = 1'b1;

  instr_fetch_seq_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  assign bus.mem_ack   = mem_ack;
  assign bus.mem_rdata = mem_rdata;
  assign bus.flush     = flush;
  assign bus.flush_pc  = flush_pc;
  assign bus.dec_ready = dec_ready;

  instr_fetch_seq #(
    .ADDR_W(16), .DATA_W(16), .QDEPTH(2), .RESET_PC(16'hC000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  exp_t        mon_a;
  logic [15:0] mem [logic [15:0]];
  logic        hold_en = 1'b0;
  logic [15:0] hold_addr = '0;

  logic        prev_valid = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_flush = 1'b0;
  logic [15:0] prev_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic expect_b(input logic [15:0] instr, input logic [15:0] ext0,
                          input logic [15:0] ext1, input logic [1:0] len,
                          input logic [1:0] fmt, input logic [15:0] pc);
    exp_t e;
    e = '{instr: instr, ext0: ext0, ext1: ext1, len: len, fmt: fmt, pc: pc};
    exp_q.push_back(e);
  endtask

  task automatic do_flush(input logic [15:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    @(negedge clk);
    flush    = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.dec_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_total++;
      n_bad++;
      $display("FAIL %s_timeout: %0d bundles outstanding, dec_valid=%b required none",
               name, exp_q.size(), bus.dec_valid);
    end
    repeat (3) @(negedge clk);
  endtask

  // Zero-wait memory: acks any loaded address unless it is being held back
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.mem_req && mem.exists(bus.mem_addr) &&
        !(hold_en && bus.mem_addr == hold_addr)) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[bus.mem_addr];
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end
  end

  // Monitor: bundle scoreboard and request-stability check
  always @(negedge clk) begin
    #1;
    if (rst_n && bus.dec_valid && bus.dec_ready && !bus.flush) begin
      mon_a = {bus.dec_instr, bus.dec_ext0, bus.dec_ext1, bus.dec_len, bus.dec_fmt, bus.dec_pc};
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_bundle: got pc=%h instr=%h, required no bundle",
                 bus.dec_pc, bus.dec_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          n_bad++;
          $display("FAIL bundle: got instr=%h ext0=%h ext1=%h len=%0d fmt=%0d pc=%h required instr=%h ext0=%h ext1=%h len=%0d fmt=%0d pc=%h",
                   mon_a.instr, mon_a.ext0, mon_a.ext1, mon_a.len, mon_a.fmt, mon_a.pc,
                   mon_e.instr, mon_e.ext0, mon_e.ext1, mon_e.len, mon_e.fmt, mon_e.pc);
        end
      end
    end
    if (rst_n && prev_valid && prev_req && !prev_ack && !prev_flush)
      chk("req_stable", {15'd0, bus.mem_req, bus.mem_addr}, {15'd0, 1'b1, prev_addr});
    prev_valid = rst_n;
    prev_req   = bus.mem_req;
    prev_ack   = bus.mem_ack;
    prev_flush = bus.flush;
    prev_addr  = bus.mem_addr;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // 1: reset state and first fetch
    mem.delete();
    mem[16'hC000] = 16'h4F0F;
    expect_b(16'h4F0F, 16'h0000, 16'h0000, 2'd1, 2'd1, 16'hC000);
    repeat (3) @(negedge clk);
    chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
    chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_q_level",   32'(bus.q_level),   32'd0);
    chk("rst_dec_data",  {bus.dec_instr, bus.dec_pc}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_first_req", {15'd0, bus.mem_req, bus.mem_addr}, {15'd0, 1'b1, 16'hC000});
    drain("t1");

    // 2: immediate source + absolute destination
    rst_n = 1'b0;
    mem.delete();
    mem[16'hC000] = 16'h40B2;
    mem[16'hC002] = 16'h1234;
    mem[16'hC004] = 16'h0200;
    expect_b(16'h40B2, 16'h1234, 16'h0200, 2'd3, 2'd1, 16'hC000);
    @(negedge clk);
    rst_n = 1'b1;
    drain("t2");
    chk("t2_next_fetch", {15'd0, bus.mem_req, bus.mem_addr}, {15'd0, 1'b1, 16'hC006});

    // 3: constant generator source, then an illegal word
    mem.delete();
    mem[16'hB000] = 16'h4392;
    mem[16'hB002] = 16'h0200;
    mem[16'hB004] = 16'h0000;
    expect_b(16'h4392, 16'h0200, 16'h0000, 2'd2, 2'd1, 16'hB000);
    expect_b(16'h0000, 16'h0000, 16'h0000, 2'd1, 2'd0, 16'hB004);
    do_flush(16'hB000);
    drain("t3");

    // 4: backpressure with four one-word ops
    mem.delete();
    mem[16'hA000] = 16'h4F0F;
    mem[16'hA002] = 16'h4303;
    mem[16'hA004] = 16'h0000;
    mem[16'hA006] = 16'h2000;
    expect_b(16'h4F0F, 16'h0000, 16'h0000, 2'd1, 2'd1, 16'hA000);
    expect_b(16'h4303, 16'h0000, 16'h0000, 2'd1, 2'd1, 16'hA002);
    expect_b(16'h0000, 16'h0000, 16'h0000, 2'd1, 2'd0, 16'hA004);
    expect_b(16'h2000, 16'h0000, 16'h0000, 2'd1, 2'd3, 16'hA006);
    dec_ready = 1'b0;
    do_flush(16'hA000);
    repeat (12) @(negedge clk);
    chk("t4_q_level_sat", 32'(bus.q_level),   32'd2);
    chk("t4_req_dropped", 32'(bus.mem_req),   32'd0);
    chk("t4_head_valid",  32'(bus.dec_valid), 32'd1);
    dec_ready = 1'b1;
    drain("t4");

    // 6: address wrap across FFFE -> 0000
    mem.delete();
    mem[16'hFFFE] = 16'h4030;
    mem[16'h0000] = 16'h1234;
    expect_b(16'h4030, 16'h1234, 16'h0000, 2'd2, 2'd1, 16'hFFFE);
    do_flush(16'hFFFE);
    drain("t6");
    chk("t6_next_fetch", {15'd0, bus.mem_req, bus.mem_addr}, {15'd0, 1'b1, 16'h0002});

    // 5: flush during EXT0 with an ack arriving in the flush cycle
    mem.delete();
    mem[16'hD000] = 16'h5092;
    mem[16'hD002] = 16'h0004;
    mem[16'hD004] = 16'h0006;
    mem[16'hE000] = 16'h4F0F;
    hold_en   = 1'b1;
    hold_addr = 16'hD002;
    do_flush(16'hD000);
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 16'hD002) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_total++;
      n_bad++;
      $display("FAIL t5_reach_ext0: mem_addr=%h mem_req=%b required D002/1",
               bus.mem_addr, bus.mem_req);
    end
    hold_en = 1'b0;
    @(negedge clk);
    chk("t5_ack_pending", 32'(bus.mem_ack), 32'd1);
    expect_b(16'h4F0F, 16'h0000, 16'h0000, 2'd1, 2'd1, 16'hE000);
    do_flush(16'hE001);
    chk("t5_req_gap",  32'(bus.mem_req),   32'd0);
    chk("t5_q_empty",  {28'd0, bus.dec_valid, bus.q_level}, 32'd0);
    @(negedge clk);
    chk("t5_new_req",  {15'd0, bus.mem_req, bus.mem_addr}, {15'd0, 1'b1, 16'hE000});
    drain("t5");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
